conv_job_sequencer: RTL and testbench

Host-side job controller for the convolution processor core. Captures a job request (sizeX, sizeY) from the register interface and validates it. Drives the core's level-sensitive init handshake: init is raised, held until done, then dropped, and the sequencer waits for done to clear. It then reports completion through sticky status, an optional interrupt and a cycle counter. Sits between the IP register block and the processor FSM/datapath.

---
 rtl/conv_pkg.sv | 25 ++
 rtl/conv_sat_counter.sv | 22 ++
 rtl/conv_job_sequencer.sv | 125 ++++++++++++
 tb/tb_conv_job_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution job sequencer and the processor datapath.
package conv_pkg;

  localparam int CONV_SIZE_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LATCH   = 3'd1,
    ST_ARM     = 3'd2,
    ST_RUN     = 3'd3,
    ST_RELEASE = 3'd4,
    ST_FINISH  = 3'd5,
    ST_ERR     = 3'd6
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_ZERO = 2'b01;
  localparam logic [1:0] ERR_BUSY = 2'b10;

  // States in which the core is being driven and the job timer runs.
  function automatic logic is_active(state_t s);
    return (s == ST_ARM) || (s == ST_RUN) || (s == ST_RELEASE);
  endfunction

endpackage

// File: rtl/conv_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module conv_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/conv_job_sequencer.sv
// Host-side job controller: validates a job request, runs the core's init/done
// handshake and reports completion through sticky status, irq and a cycle count.
//
// state   | meaning
// IDLE    | waiting for an accepted start
// LATCH   | sizes held, zero-size check
// ARM     | init raised, first active cycle
// RUN     | init held until core done
// RELEASE | init dropped, waiting for done to clear
// FINISH  | set done/irq, back to IDLE
// ERR     | zero-size job rejected; flags already set on entry
module conv_job_sequencer
  import conv_pkg::*;
#(
  parameter int SIZE_W  = CONV_SIZE_W,
  parameter int CYCLE_W = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start_in,
  input  logic [SIZE_W-1:0]  sizeX_in,
  input  logic [SIZE_W-1:0]  sizeY_in,
  input  logic               irq_en_in,
  input  logic               irq_clr_in,
  input  logic               conv_done_in,
  input  logic               conv_busy_in,
  output logic               conv_init_out,
  output logic [SIZE_W-1:0]  sizeX_out,
  output logic [SIZE_W-1:0]  sizeY_out,
  output logic               busy_out,
  output logic               done_out,
  output logic [1:0]         err_out,
  output logic               irq_out,
  output logic [CYCLE_W-1:0] cycles_out
);

  state_t state;
  logic   accept;
  logic   core_busy_unused;

  // Core busy is status-only here; the register block reads it directly.
  assign core_busy_unused = conv_busy_in;
  assign accept           = (state == ST_IDLE) && start_in;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= ST_IDLE;
      conv_init_out <= 1'b0;
      sizeX_out     <= '0;
      sizeY_out     <= '0;
      busy_out      <= 1'b0;
      done_out      <= 1'b0;
      err_out       <= ERR_NONE;
      irq_out       <= 1'b0;
    end else begin
      // Clear first so any set later in this block wins a same-cycle collision.
      if (irq_clr_in) irq_out <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start_in) begin
            sizeX_out <= sizeX_in;
            sizeY_out <= sizeY_in;
            done_out  <= 1'b0;
            err_out   <= ERR_NONE;
            busy_out  <= 1'b1;
            state     <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          if ((sizeX_out == '0) || (sizeY_out == '0)) begin
            err_out  <= ERR_ZERO;
            done_out <= 1'b1;
            if (irq_en_in) irq_out <= 1'b1;
            state    <= ST_ERR;
          end else begin
            conv_init_out <= 1'b1;
            state         <= ST_ARM;
          end
        end
        ST_ARM: begin
          state <= ST_RUN;
        end
        ST_RUN: begin
          if (conv_done_in) begin
            conv_init_out <= 1'b0;
            state         <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!conv_done_in) state <= ST_FINISH;
        end
        ST_FINISH: begin
          done_out <= 1'b1;
          if (irq_en_in) irq_out <= 1'b1;
          busy_out <= 1'b0;
          state    <= ST_IDLE;
        end
        ST_ERR: begin
          busy_out <= 1'b0;
          state    <= ST_IDLE;
        end
        default: begin
          conv_init_out <= 1'b0;
          busy_out      <= 1'b0;
          state         <= ST_IDLE;
        end
      endcase

      // A start while a job is in flight is dropped but flagged; overrides a zero-size code.
      if (start_in && (state != ST_IDLE)) err_out <= ERR_BUSY;
    end
  end

  conv_sat_counter #(
    .W(CYCLE_W)
  ) u_cycles (
    .clk  (clk),
    .rstn (rstn),
    .clr  (accept),
    .en   (is_active(state)),
    .count(cycles_out)
  );

endmodule

// File: tb/tb_conv_job_sequencer.sv
// Scoreboard bench: two sequencers (16-bit and 4-bit cycle counters) share one
// stimulus stream and a behavioural core model; completions are checked by a monitor.
module tb_conv_job_sequencer;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       start_in = 1'b0;
  logic [4:0] sizeX_in = '0;
  logic [4:0] sizeY_in = '0;
  logic       irq_en_in = 1'b0;
  logic       irq_clr_in = 1'b0;
  logic       conv_done_in = 1'b0;
  logic       conv_busy_in = 1'b0;

  logic        conv_init_out, busy_out, done_out, irq_out;
  logic [4:0]  sizeX_out, sizeY_out;
  logic [1:0]  err_out;
  logic [15:0] cycles_out;

  logic        init4, busy4, done4, irq4;
  logic [4:0]  sx4, sy4;
  logic [1:0]  err4;
  logic [3:0]  cycles4;

  conv_job_sequencer #(.SIZE_W(5), .CYCLE_W(16)) dut (
    .clk(clk), .rstn(rstn), .start_in(start_in), .sizeX_in(sizeX_in), .sizeY_in(sizeY_in),
    .irq_en_in(irq_en_in), .irq_clr_in(irq_clr_in), .conv_done_in(conv_done_in),
    .conv_busy_in(conv_busy_in), .conv_init_out(conv_init_out), .sizeX_out(sizeX_out),
    .sizeY_out(sizeY_out), .busy_out(busy_out), .done_out(done_out), .err_out(err_out),
    .irq_out(irq_out), .cycles_out(cycles_out)
  );

  conv_job_sequencer #(.SIZE_W(5), .CYCLE_W(4)) dut_sat (
    .clk(clk), .rstn(rstn), .start_in(start_in), .sizeX_in(sizeX_in), .sizeY_in(sizeY_in),
    .irq_en_in(irq_en_in), .irq_clr_in(irq_clr_in), .conv_done_in(conv_done_in),
    .conv_busy_in(conv_busy_in), .conv_init_out(init4), .sizeX_out(sx4),
    .sizeY_out(sy4), .busy_out(busy4), .done_out(done4), .err_out(err4),
    .irq_out(irq4), .cycles_out(cycles4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] sx;
    logic [4:0] sy;
    logic [1:0] err;
    logic       irq;
    int         cycles;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   init_rises = 0;
  int   exp_init_rises = 0;
  logic irq_model = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Completion monitor: a falling busy_out presents a finished job.
  initial begin
    logic pb;
    exp_t e;
    pb = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        pb = 1'b0;
      end else begin
        if (pb && !busy_out) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_completion: got a job end, expected none at %0t", $time);
          end else begin
            e = sb_q.pop_front();
            chk("done_out", done_out, 1);
            chk("err_out", err_out, e.err);
            chk("irq_out", irq_out, e.irq);
            chk("sizeX_out", sizeX_out, e.sx);
            chk("sizeY_out", sizeY_out, e.sy);
            chk("cycles16", cycles_out, (e.cycles > 65535) ? 65535 : e.cycles);
            chk("cycles4_sat", cycles4, (e.cycles > 15) ? 15 : e.cycles);
          end
        end
        pb = busy_out;
      end
    end
  end

  initial begin
    logic pi;
    pi = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) pi = 1'b0;
      else begin
        if (conv_init_out && !pi) init_rises++;
        pi = conv_init_out;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    sizeX_in = 5'($urandom_range(0, 31));
    sizeY_in = 5'($urandom_range(0, 31));
  endtask

  // One job: model result pushed at issue, core model replies d cycles after init,
  // drops done r cycles after init falls.
  task automatic run_job(input logic [4:0] sx, input logic [4:0] sy, input logic ie,
                         input int d, input int r, input logic busy_start, input logic clr_fin);
    exp_t e;
    logic zero;
    int   n;
    zero     = (sx == 0) || (sy == 0);
    e.sx     = sx;
    e.sy     = sy;
    e.err    = zero ? 2'b01 : (busy_start ? 2'b10 : 2'b00);
    e.cycles = zero ? 0 : d + r + 2;
    if (ie) e.irq = 1'b1;
    else if (clr_fin && !zero) e.irq = 1'b0;
    else e.irq = irq_model;
    irq_model = e.irq;
    if (!zero) exp_init_rises++;
    sb_q.push_back(e);

    tick();
    start_in = 1'b1; sizeX_in = sx; sizeY_in = sy; irq_en_in = ie;
    tick();
    start_in = 1'b0;
    chk("latch_busy", busy_out, 1);
    chk("latch_init", conv_init_out, 0);
    tick();
    if (zero) begin
      chk("zero_err", err_out, 2'b01);
      chk("zero_done", done_out, 1);
      chk("zero_irq", irq_out, e.irq);
      chk("zero_init", conv_init_out, 0);
      tick();
      chk("zero_busy_low", busy_out, 0);
      chk("zero_init_after", conv_init_out, 0);
      return;
    end
    chk("init_latency", conv_init_out, 1);
    n = 0;
    while (!conv_init_out && n < 8) begin
      tick();
      n++;
    end
    for (int k = 1; k <= d; k++) begin
      tick();
      if (busy_start && k == 1) begin start_in = 1'b1; sizeX_in = 5'd7; end
      if (busy_start && k == 2) start_in = 1'b0;
      chk("init_hold", conv_init_out, 1);
    end
    conv_done_in = 1'b1;
    tick();
    chk("init_drop", conv_init_out, 0);
    for (int k = 0; k < r; k++) begin
      tick();
      chk("init_low_release", conv_init_out, 0);
    end
    conv_done_in = 1'b0;
    tick();
    chk("finish_busy", busy_out, 1);
    if (clr_fin) irq_clr_in = 1'b1;
    tick();
    irq_clr_in = 1'b0;
    chk("job_end_busy", busy_out, 0);
  endtask

  task automatic idle_gap(input int n, input logic do_clr);
    for (int k = 0; k < n; k++) begin
      tick();
      chk("idle_init", conv_init_out, 0);
    end
    if (do_clr) begin
      irq_clr_in = 1'b1;
      tick();
      irq_clr_in = 1'b0;
      irq_model  = 1'b0;
      chk("irq_clr", irq_out, 0);
    end
  endtask

  initial begin
    logic [4:0] sx, sy;
    logic ie, bs, cf;
    int d, r;

    #1 rstn = 1'b0;
    #2;
    chk("rst_init", conv_init_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_done", done_out, 0);
    chk("rst_err", err_out, 0);
    chk("rst_irq", irq_out, 0);
    chk("rst_sizeX", sizeX_out, 0);
    chk("rst_sizeY", sizeY_out, 0);
    chk("rst_cycles", cycles_out, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    run_job(5'd5, 5'd3, 1'b1, 20, 2, 1'b0, 1'b0);
    idle_gap(2, 1'b0);
    run_job(5'd0, 5'd4, 1'b1, 1, 0, 1'b0, 1'b0);
    idle_gap(2, 1'b1);
    run_job(5'd5, 5'd3, 1'b1, 10, 1, 1'b1, 1'b0);
    idle_gap(1, 1'b1);
    run_job(5'd6, 5'd2, 1'b1, 5, 1, 1'b0, 1'b1);
    idle_gap(2, 1'b1);
    run_job(5'd4, 5'd4, 1'b0, 6, 0, 1'b0, 1'b0);
    idle_gap(1, 1'b0);
    run_job(5'd3, 5'd3, 1'b1, 30, 0, 1'b0, 1'b0);

    for (int j = 0; j < 20; j++) begin
      sx = 5'($urandom_range(0, 31));
      sy = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 4) == 0) sx = 5'd0;
      ie = 1'($urandom_range(0, 1));
      bs = (sx != 0) && (sy != 0) && ($urandom_range(0, 3) == 0);
      d  = bs ? int'($urandom_range(3, 25)) : int'($urandom_range(1, 25));
      r  = int'($urandom_range(0, 4));
      cf = ($urandom_range(0, 2) == 0);
      run_job(sx, sy, ie, d, r, bs, cf);
      idle_gap(int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a running job.
    tick();
    start_in = 1'b1; sizeX_in = 5'd9; sizeY_in = 5'd2; irq_en_in = 1'b1;
    exp_init_rises++;
    tick();
    start_in = 1'b0;
    repeat (4) tick();
    chk("pre_reset_init", conv_init_out, 1);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_init", conv_init_out, 0);
    chk("mid_rst_busy", busy_out, 0);
    chk("mid_rst_cycles", cycles_out, 0);
    chk("mid_rst_cycles4", cycles4, 0);
    chk("mid_rst_sizeX", sizeX_out, 0);
    chk("mid_rst_irq", irq_out, 0);
    irq_model = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    idle_gap(2, 1'b0);
    run_job(5'd7, 5'd2, 1'b1, 8, 1, 1'b0, 1'b0);

    repeat (3) tick();
    chk("scoreboard_drain", sb_q.size(), 0);
    chk("init_count", init_rises, exp_init_rises);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
